spi_flash_port: RTL and testbench

SPI_FLASH_PORT -- requirements
Module: spi_flash_port

---
 rtl/spi_flash_port.sv | 191 +++++++++++++++++++
 tb/tb_spi_flash_port.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_port.sv
`timescale 1ns/1ps
// spi_flash_port
// ---------------------------------------------------------------------------
// Zorro slave register port to a serial SPI flash. There are two byte-wide
// registers in the SPI window:
//   DATA (REG=0)  write: starts one 8-bit mode-0 transfer, MSB first.
//                 read : returns the last received byte.
//                 Both stall (no spi_dtack) while a transfer is in progress.
//   CTRL (REG=1)  write: cs_en = DIN[0], SPI_CS_n = ~cs_en.
//                 read : {busy, 6'b0, cs_en}. Never stalls.
//
// Ports
//   CLK, RESET_n        board clock (rising edge), async active-low reset
//   FCS_n               buffered Zorro cycle strobe (active low)
//   slave_cycle         card is the bus slave
//   configured          Autoconfig has assigned the base address
//   sel                 decoded address hits the SPI register window
//   REG, READ           register select (0=DATA, 1=CTRL), 1=read / 0=write
//   DIN[7:0]            write data (D[31:24])
//   DOUT[7:0]           read data, valid while spi_dtack=1
//   spi_dtack           cycle acknowledge, held until FCS_n returns high
//   SPI_CLK, SPI_MOSI, SPI_CS_n, SPI_MISO   serial flash pins
//   dbg_state_o[1:0]    current FSM state (IDLE=0, LOAD=1, SHIFT=2, DONE=3)
//
// Bus handshake: an access is taken when FCS_n=0, sel=1, slave_cycle=1 and
// configured=1, at most once per FCS_n low period. spi_dtack rises on the
// accepting edge, stays high while FCS_n is low and drops on the first edge
// that sees FCS_n high.
//
// Build option: define SPI_FAST_EN for a 2-CLK SPI_CLK period (16-CLK shift)
// instead of the default 4-CLK period (32-CLK shift).
// ---------------------------------------------------------------------------
module spi_flash_port (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       FCS_n,
  input  logic       slave_cycle,
  input  logic       configured,
  input  logic       sel,
  input  logic       REG,
  input  logic       READ,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       spi_dtack,
  output logic       SPI_CLK,
  output logic       SPI_MOSI,
  output logic       SPI_CS_n,
  input  logic       SPI_MISO,
  output logic [1:0] dbg_state_o
);

`ifdef SPI_FAST_EN
  localparam int unsigned CW = 1;
  localparam logic [CW-1:0] CNT_SAMPLE = 1'b0;  // SPI_CLK rises on 0->1
  localparam logic [CW-1:0] CNT_LAST   = 1'b1;  // SPI_CLK falls on 1->0
`else
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] CNT_SAMPLE = 2'd1;  // SPI_CLK rises on 1->2
  localparam logic [CW-1:0] CNT_LAST   = 2'd3;  // SPI_CLK falls on 3->0
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            miso_q, miso_d;
  logic            mosi_q, mosi_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      dout_q, dout_d;
  logic            dtack_q, dtack_d;
  logic            taken_q, taken_d;
  logic            cs_en_q, cs_en_d;

  logic            busy;
  logic            access;
  logic            data_ok;
  logic            ctrl_ok;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      miso_q  <= 1'b0;
      mosi_q  <= 1'b0;
      rx_q    <= 8'h00;
      dout_q  <= 8'h00;
      dtack_q <= 1'b0;
      taken_q <= 1'b0;
      cs_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      miso_q  <= miso_d;
      mosi_q  <= mosi_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      dtack_q <= dtack_d;
      taken_q <= taken_d;
      cs_en_q <= cs_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    miso_d  = miso_q;
    mosi_d  = mosi_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    dtack_d = dtack_q;
    taken_d = taken_q;
    cs_en_d = cs_en_q;

    busy    = (state_q != S_IDLE);
    access  = ~FCS_n & sel & slave_cycle & configured & ~taken_q;
    // DATA accesses wait for IDLE; CTRL accesses go through at any time.
    data_ok = access & ~REG & ~busy;
    ctrl_ok = access & REG;

    // Bus side: acknowledge and register access.
    if (FCS_n) begin
      dtack_d = 1'b0;
      taken_d = 1'b0;
    end else if (data_ok || ctrl_ok) begin
      dtack_d = 1'b1;
      taken_d = 1'b1;
      if (REG) begin
        if (READ) dout_d  = {busy, 6'b000000, cs_en_q};
        else      cs_en_d = DIN[0];
      end else if (READ) begin
        dout_d = rx_q;
      end
    end

    // Transfer engine. FCS_n plays no part here, so a transfer always runs
    // to completion once started.
    case (state_q)
      S_IDLE: begin
        if (data_ok && !READ) begin
          shreg_d = DIN;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mosi_d  = shreg_q[7];
        cnt_d   = '0;
        bit_d   = 3'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        // MISO is held in its own flop until the falling SPI_CLK edge so the
        // outgoing bit 0 is not overwritten before it has been sent.
        if (cnt_q == CNT_SAMPLE) miso_d = SPI_MISO;
        if (cnt_q == CNT_LAST) begin
          shreg_d = {shreg_q[6:0], miso_q};
          mosi_d  = shreg_q[6];
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_DONE;
        end
      end
      S_DONE: begin
        rx_d    = shreg_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SPI_CLK is only ever high in SHIFT, so it idles low in every other state.
  assign SPI_CLK     = (state_q == S_SHIFT) & cnt_q[CW-1];
  assign SPI_MOSI    = mosi_q;
  assign SPI_CS_n    = ~cs_en_q;
  assign spi_dtack   = dtack_q;
  assign DOUT        = dout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_flash_port.sv
`timescale 1ns/1ps
// Bench for spi_flash_port: directed bus accesses through driver tasks, a
// scoreboard queue of expected read data popped by a monitor on each rising
// spi_dtack of a read, and direct pin/timing checks in the main sequence.
module tb_spi_flash_port;

`ifdef SPI_FAST_EN
  localparam int XFER = 18;  // accept edge to busy clear
  localparam int BITC = 2;   // CLK per SPI bit
`else
  localparam int XFER = 34;
  localparam int BITC = 4;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       CLK = 1'b0;
  logic       RESET_n;
  logic       FCS_n, slave_cycle, configured, sel, REG, READ;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       spi_dtack, SPI_CLK, SPI_MOSI, SPI_CS_n, SPI_MISO;
  logic [1:0] dbg_state;
  logic       loopback = 1'b1;
  logic       miso_fix = 1'b0;

  always #20 CLK = ~CLK;  // 25 MHz

  assign SPI_MISO = loopback ? SPI_MOSI : miso_fix;

  spi_flash_port dut (
    .CLK         (CLK),
    .RESET_n     (RESET_n),
    .FCS_n       (FCS_n),
    .slave_cycle (slave_cycle),
    .configured  (configured),
    .sel         (sel),
    .REG         (REG),
    .READ        (READ),
    .DIN         (DIN),
    .DOUT        (DOUT),
    .spi_dtack   (spi_dtack),
    .SPI_CLK     (SPI_CLK),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_CS_n    (SPI_CS_n),
    .SPI_MISO    (SPI_MISO),
    .dbg_state_o (dbg_state)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic       mosi_log[$];
  int         tests  = 0;
  int         failed = 0;

  always @(posedge SPI_CLK) mosi_log.push_back(SPI_MOSI);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] log_byte(input int base);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      if (base + i < mosi_log.size()) b[7-i] = mosi_log[base+i];
    return b;
  endfunction

  // Monitor: every read acknowledge is compared against the queue head.
  logic mon_prev = 1'b0;
  always @(negedge CLK) begin
    if (spi_dtack && !mon_prev && READ) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL read_unexpected: got 0x%0h expected no read ack", DOUT);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (DOUT !== e) begin
          failed++;
          $display("FAIL read_data: got 0x%0h expected 0x%0h (cyc %0d)", DOUT, e, cyc);
        end
      end
    end
    mon_prev = spi_dtack;
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge. Returns the cycle number at which spi_dtack was
  // first seen; FCS_n is kept low for 'hold' more cycles after that.
  task automatic bus_access(input logic r, input logic rd, input logic [7:0] din,
                            input logic [7:0] exp, input int hold, output int acc);
    int t;
    int lows;
    if (rd) exp_q.push_back(exp);
    FCS_n = 1'b0; sel = 1'b1; slave_cycle = 1'b1; configured = 1'b1;
    REG = r; READ = rd; DIN = din;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!spi_dtack && t < 200);
    check("dtack_seen", spi_dtack, 1'b1);
    acc  = cyc;
    lows = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (!spi_dtack) lows++;
    end
    if (hold > 0) check("dtack_held", lows, 0);
    FCS_n = 1'b1; sel = 1'b0;
    @(negedge CLK);
    check("dtack_clear", spi_dtack, 1'b0);
  endtask

  task automatic wait_idle(output int t);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (dbg_state != 2'd0 && n < 200);
    check("idle_reached", dbg_state, 2'd0);
    t = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int e, e2, a, k, t, n_dt, n_st;
    logic [7:0] expv;

    RESET_n = 1'b0; FCS_n = 1'b1; slave_cycle = 1'b0; configured = 1'b0;
    sel = 1'b0; REG = 1'b0; READ = 1'b0; DIN = 8'h00;
    repeat (3) @(negedge CLK);
    check("rst_cs_n",  SPI_CS_n,  1'b1);
    check("rst_clk",   SPI_CLK,   1'b0);
    check("rst_mosi",  SPI_MOSI,  1'b0);
    check("rst_dtack", spi_dtack, 1'b0);
    check("rst_dout",  DOUT,      8'h00);
    check("rst_state", dbg_state, 2'd0);
    RESET_n = 1'b1;
    @(negedge CLK);

    // Chip select on, loopback transfer of 0xA5.
    bus_access(1'b1, 1'b0, 8'h01, 8'h00, 0, a);
    check("cs_on", SPI_CS_n, 1'b0);
    bus_access(1'b1, 1'b1, 8'h00, 8'h01, 0, a);
    mosi_log.delete();
    loopback = 1'b1;
    bus_access(1'b0, 1'b0, 8'hA5, 8'h00, 0, e);
    wait_idle(t);
    check("a5_busy_clear", t - e, XFER);
    check("a5_pulses", mosi_log.size(), 8);
    check("a5_mosi", log_byte(0), 8'hA5);
    bus_access(1'b0, 1'b1, 8'h00, 8'hA5, 0, a);

    // Back-to-back DATA writes: the second stalls until the first is done.
    mosi_log.delete();
    bus_access(1'b0, 1'b0, 8'h3C, 8'h00, 0, e);
    while (cyc < e + 4) @(negedge CLK);
    bus_access(1'b0, 1'b0, 8'h96, 8'h00, 0, e2);
    check("stall_ack_not_early", (e2 >= e + XFER + 1), 1'b1);
    wait_idle(t);
    check("b2b_pulses", mosi_log.size(), 16);
    check("b2b_byte0", log_byte(0), 8'h3C);
    check("b2b_byte1", log_byte(8), 8'h96);
    bus_access(1'b0, 1'b1, 8'h00, 8'h96, 0, a);

    // CTRL polling during a transfer.
    bus_access(1'b0, 1'b0, 8'h5A, 8'h00, 0, e);
    while (cyc < e + XFER + 6) begin
      k    = cyc;
      expv = (k + 1 <= e + XFER) ? 8'h81 : 8'h01;
      bus_access(1'b1, 1'b1, 8'h00, expv, 0, a);
      check("poll_ack_within_2", ((a - k) <= 2), 1'b1);
    end
    bus_access(1'b0, 1'b1, 8'h00, 8'h5A, 0, a);

    // FCS_n held low for 50 CLK after one DATA write.
    mosi_log.delete();
    bus_access(1'b0, 1'b0, 8'h0F, 8'h00, 50, e);
    check("hold_one_transfer", mosi_log.size(), 8);
    check("hold_byte", log_byte(0), 8'h0F);
    check("hold_idle", dbg_state, 2'd0);
    bus_access(1'b0, 1'b1, 8'h00, 8'h0F, 0, a);

    // Chip select dropped mid-transfer; the shift still completes.
    mosi_log.delete();
    bus_access(1'b0, 1'b0, 8'hC3, 8'h00, 0, e);
    bus_access(1'b1, 1'b0, 8'h00, 8'h00, 0, a);
    check("cs_off_now", SPI_CS_n, 1'b1);
    check("cs_off_still_busy", (dbg_state != 2'd0), 1'b1);
    wait_idle(t);
    check("cs_off_byte", log_byte(0), 8'hC3);
    bus_access(1'b1, 1'b0, 8'h01, 8'h00, 0, a);

    // Unconfigured card ignores the access.
    FCS_n = 1'b0; sel = 1'b1; slave_cycle = 1'b1; configured = 1'b0;
    REG = 1'b0; READ = 1'b0; DIN = 8'hEE;
    n_dt = 0; n_st = 0;
    repeat (10) begin
      @(negedge CLK);
      if (spi_dtack) n_dt++;
      if (dbg_state != 2'd0) n_st++;
    end
    check("unconf_no_dtack", n_dt, 0);
    check("unconf_no_start", n_st, 0);
    FCS_n = 1'b1; sel = 1'b0; configured = 1'b1;
    @(negedge CLK);

    // MISO tied low: received byte is 0x00.
    loopback = 1'b0; miso_fix = 1'b0;
    bus_access(1'b0, 1'b0, 8'hFF, 8'h00, 0, e);
    wait_idle(t);
    check("ff_busy_clear", t - e, XFER);
    bus_access(1'b0, 1'b1, 8'h00, 8'h00, 0, a);
    loopback = 1'b1;

    // Reset in the middle of bit 4 with FCS_n still low.
    FCS_n = 1'b0; sel = 1'b1; slave_cycle = 1'b1; configured = 1'b1;
    REG = 1'b0; READ = 1'b0; DIN = 8'h77;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!spi_dtack && k < 200);
    check("rst_mid_dtack", spi_dtack, 1'b1);
    e = cyc;
    while (cyc < e + 1 + 4 * BITC + BITC / 2) @(negedge CLK);
    check("rst_mid_clk_high", SPI_CLK, 1'b1);
    RESET_n = 1'b0;
    #1;
    check("rst_mid_clk",   SPI_CLK,   1'b0);
    check("rst_mid_cs_n",  SPI_CS_n,  1'b1);
    check("rst_mid_dtack0", spi_dtack, 1'b0);
    check("rst_mid_state", dbg_state, 2'd0);
    check("rst_mid_dout",  DOUT,      8'h00);
    FCS_n = 1'b1; sel = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    k = cyc;
    bus_access(1'b1, 1'b1, 8'h00, 8'h00, 0, a);
    check("post_rst_first_edge", a - k, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
